// File: rtl/pyrm_pkg.sv
// Shared register-file definitions used by decode, write-back and the register file.
package pyrm_pkg;

    localparam int XLEN      = 64;
    localparam int NREGS     = 32;
    localparam int REG_IDX_W = 5;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xlen_t;

endpackage

// File: rtl/pyrm_reg_file_read_port.sv
// One source-operand read port: accept decision, registered operand, hold while the consumer stalls.
module pyrm_reg_file_read_port
    import pyrm_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  addr_valid,
    input  logic  data_retry,
    input  xlen_t arr_data,
    input  logic  busy,
    input  logic  byp_hit,
    input  xlen_t byp_data,
    output logic  addr_retry,
    output xlen_t data,
    output logic  data_valid
);

    xlen_t data_reg, data_next;
    logic  valid_reg, valid_next;
    logic  slot_free, src_ready, accept;

    always_comb begin
        slot_free  = !valid_reg || !data_retry;
        src_ready  = !busy || byp_hit;
        accept     = addr_valid && slot_free && src_ready;
        addr_retry = addr_valid && !accept;
        data_next  = data_reg;
        valid_next = valid_reg;
        if (accept) begin
            data_next  = byp_hit ? byp_data : arr_data;
            valid_next = 1'b1;
        end else if (slot_free) begin
            // Operand consumed (or slot already empty) with nothing new behind it.
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            data_reg  <= data_next;
            valid_reg <= valid_next;
        end
    end

    assign data       = data_reg;
    assign data_valid = valid_reg;

endmodule

// File: rtl/pyrm_reg_file.sv
// Integer register file x0..x31 with a RAW busy scoreboard, one write port and two read ports.
// Build option PYRM_REGFILE_BYPASS_EN forwards a same-cycle write straight to a waiting read.
module pyrm_reg_file
    import pyrm_pkg::*;
(
    input  logic        clk,
    input  logic        reset_pyri,
    input  logic [63:0] wr_addr_pyri,
    input  logic        wr_addr_valid_pyri,
    output logic        wr_addr_retry_pyro,
    input  xlen_t       wr_data_pyri,
    input  logic        wr_data_valid_pyri,
    output logic        wr_data_retry_pyro,
    input  reg_idx_t    claim_pyri,
    input  logic        claim_valid_pyri,
    output logic        claim_retry_pyro,
    input  reg_idx_t    rs1_addr_pyri,
    input  logic        rs1_addr_valid_pyri,
    output logic        rs1_addr_retry_pyro,
    output xlen_t       rs1_data_pyro,
    output logic        rs1_data_valid_pyro,
    input  logic        rs1_data_retry_pyri,
    input  reg_idx_t    rs2_addr_pyri,
    input  logic        rs2_addr_valid_pyri,
    output logic        rs2_addr_retry_pyro,
    output xlen_t       rs2_data_pyro,
    output logic        rs2_data_valid_pyro,
    input  logic        rs2_data_retry_pyri
);

    xlen_t            regs_reg [NREGS];
    logic [NREGS-1:0] busy_reg;

    reg_idx_t wr_idx;
    logic     wr_fire, claim_fire;
    logic     unused_wr_addr_hi;

    assign wr_idx            = wr_addr_pyri[REG_IDX_W-1:0];
    assign unused_wr_addr_hi = ^wr_addr_pyri[63:REG_IDX_W];
    assign wr_fire           = wr_addr_valid_pyri && wr_data_valid_pyri;

    assign wr_addr_retry_pyro = 1'b0;
    assign wr_data_retry_pyro = 1'b0;

    // A write landing on the claimed register this cycle frees it, so the claim may proceed.
    assign claim_retry_pyro = claim_valid_pyri && busy_reg[claim_pyri]
                              && !(wr_fire && (wr_idx == claim_pyri));
    assign claim_fire       = claim_valid_pyri && !claim_retry_pyro;

    // Claim is applied after the write clear so a same-cycle claim keeps the register busy.
    always_ff @(posedge clk or negedge reset_pyri) begin
        if (!reset_pyri) begin
            busy_reg <= '0;
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else begin
            busy_reg[0] <= 1'b0;
            regs_reg[0] <= '0;
            for (int i = 1; i < NREGS; i++) begin
                if (wr_fire && (wr_idx == reg_idx_t'(i))) begin
                    regs_reg[i] <= wr_data_pyri;
                    busy_reg[i] <= 1'b0;
                end
                if (claim_fire && (claim_pyri == reg_idx_t'(i))) busy_reg[i] <= 1'b1;
            end
        end
    end

    reg_idx_t rs_addr       [2];
    logic     rs_addr_valid [2];
    logic     rs_data_retry [2];
    logic     rs_addr_retry [2];
    xlen_t    rs_data       [2];
    logic     rs_data_valid [2];
    logic     byp_hit       [2];

    assign rs_addr[0]       = rs1_addr_pyri;
    assign rs_addr[1]       = rs2_addr_pyri;
    assign rs_addr_valid[0] = rs1_addr_valid_pyri;
    assign rs_addr_valid[1] = rs2_addr_valid_pyri;
    assign rs_data_retry[0] = rs1_data_retry_pyri;
    assign rs_data_retry[1] = rs2_data_retry_pyri;

    assign rs1_addr_retry_pyro = rs_addr_retry[0];
    assign rs1_data_pyro       = rs_data[0];
    assign rs1_data_valid_pyro = rs_data_valid[0];
    assign rs2_addr_retry_pyro = rs_addr_retry[1];
    assign rs2_data_pyro       = rs_data[1];
    assign rs2_data_valid_pyro = rs_data_valid[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
`ifdef PYRM_REGFILE_BYPASS_EN
            assign byp_hit[gi] = wr_fire && (wr_idx == rs_addr[gi]) && (wr_idx != '0);
`else
            assign byp_hit[gi] = 1'b0;
`endif
            pyrm_reg_file_read_port u_port (
                .clk        (clk),
                .rst_n      (reset_pyri),
                .addr_valid (rs_addr_valid[gi]),
                .data_retry (rs_data_retry[gi]),
                .arr_data   (regs_reg[rs_addr[gi]]),
                .busy       (busy_reg[rs_addr[gi]]),
                .byp_hit    (byp_hit[gi]),
                .byp_data   (wr_data_pyri),
                .addr_retry (rs_addr_retry[gi]),
                .data       (rs_data[gi]),
                .data_valid (rs_data_valid[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_pyrm_reg_file.sv
// Directed bench for pyrm_reg_file; operand values are checked through per-port expectation queues.
module tb_pyrm_reg_file;
    import pyrm_pkg::*;

    logic        clk = 1'b0;
    logic        reset_pyri = 1'b0;
    logic [63:0] wr_addr_pyri = '0;
    logic        wr_addr_valid_pyri = 1'b0;
    logic        wr_addr_retry_pyro;
    xlen_t       wr_data_pyri = '0;
    logic        wr_data_valid_pyri = 1'b0;
    logic        wr_data_retry_pyro;
    reg_idx_t    claim_pyri = '0;
    logic        claim_valid_pyri = 1'b0;
    logic        claim_retry_pyro;
    reg_idx_t    rs1_addr_pyri = '0;
    logic        rs1_addr_valid_pyri = 1'b0;
    logic        rs1_addr_retry_pyro;
    xlen_t       rs1_data_pyro;
    logic        rs1_data_valid_pyro;
    logic        rs1_data_retry_pyri = 1'b0;
    reg_idx_t    rs2_addr_pyri = '0;
    logic        rs2_addr_valid_pyri = 1'b0;
    logic        rs2_addr_retry_pyro;
    xlen_t       rs2_data_pyro;
    logic        rs2_data_valid_pyro;
    logic        rs2_data_retry_pyri = 1'b0;

    int    total = 0;
    int    bad   = 0;
    xlen_t q1[$];
    xlen_t q2[$];

    always #5 clk = ~clk;

    pyrm_reg_file dut (
        .clk                 (clk),
        .reset_pyri          (reset_pyri),
        .wr_addr_pyri        (wr_addr_pyri),
        .wr_addr_valid_pyri  (wr_addr_valid_pyri),
        .wr_addr_retry_pyro  (wr_addr_retry_pyro),
        .wr_data_pyri        (wr_data_pyri),
        .wr_data_valid_pyri  (wr_data_valid_pyri),
        .wr_data_retry_pyro  (wr_data_retry_pyro),
        .claim_pyri          (claim_pyri),
        .claim_valid_pyri    (claim_valid_pyri),
        .claim_retry_pyro    (claim_retry_pyro),
        .rs1_addr_pyri       (rs1_addr_pyri),
        .rs1_addr_valid_pyri (rs1_addr_valid_pyri),
        .rs1_addr_retry_pyro (rs1_addr_retry_pyro),
        .rs1_data_pyro       (rs1_data_pyro),
        .rs1_data_valid_pyro (rs1_data_valid_pyro),
        .rs1_data_retry_pyri (rs1_data_retry_pyri),
        .rs2_addr_pyri       (rs2_addr_pyri),
        .rs2_addr_valid_pyri (rs2_addr_valid_pyri),
        .rs2_addr_retry_pyro (rs2_addr_retry_pyro),
        .rs2_data_pyro       (rs2_data_pyro),
        .rs2_data_valid_pyro (rs2_data_valid_pyro),
        .rs2_data_retry_pyri (rs2_data_retry_pyri)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_set(input int idx, input logic [63:0] val);
        wr_addr_pyri       = 64'(idx);
        wr_data_pyri       = val;
        wr_addr_valid_pyri = 1'b1;
        wr_data_valid_pyri = 1'b1;
    endtask

    task automatic wr_clr();
        wr_addr_valid_pyri = 1'b0;
        wr_data_valid_pyri = 1'b0;
    endtask

    // A consumed operand (valid and not stalled) is matched against the oldest expectation.
    always @(negedge clk) begin
        if (reset_pyri && rs1_data_valid_pyro && !rs1_data_retry_pyri) begin
            if (q1.size() == 0) chk("rs1_unexpected_valid", 64'd1, 64'd0);
            else chk("rs1_scoreboard", rs1_data_pyro, q1.pop_front());
            $display("rs1 consumed data=%0h", rs1_data_pyro);
        end
        if (reset_pyri && rs2_data_valid_pyro && !rs2_data_retry_pyri) begin
            if (q2.size() == 0) chk("rs2_unexpected_valid", 64'd1, 64'd0);
            else chk("rs2_scoreboard", rs2_data_pyro, q2.pop_front());
            $display("rs2 consumed data=%0h", rs2_data_pyro);
        end
    end

    initial begin
        // reset state
        tick();
        tick();
        chk("reset_rs1_valid", 64'(rs1_data_valid_pyro), 64'd0);
        chk("reset_rs1_data", rs1_data_pyro, 64'd0);
        chk("reset_rs2_valid", 64'(rs2_data_valid_pyro), 64'd0);
        chk("wr_retry_tied", 64'({wr_addr_retry_pyro, wr_data_retry_pyro}), 64'd0);
        reset_pyri = 1'b1;
        tick();

        // 1: read x5 after reset, write to x0 is discarded
        rs1_addr_pyri = 5'd5; rs1_addr_valid_pyri = 1'b1;
        #1 chk("t1_read_x5_retry", 64'(rs1_addr_retry_pyro), 64'd0);
        q1.push_back(64'd0);
        tick();
        rs1_addr_valid_pyri = 1'b0;
        chk("t1_x5_valid", 64'(rs1_data_valid_pyro), 64'd1);
        chk("t1_x5_data", rs1_data_pyro, 64'd0);
        wr_set(0, 64'hDEAD);
        tick();
        wr_clr();
        chk("t1_valid_drop", 64'(rs1_data_valid_pyro), 64'd0);
        rs1_addr_pyri = 5'd0; rs1_addr_valid_pyri = 1'b1;
        q1.push_back(64'd0);
        tick();
        rs1_addr_valid_pyri = 1'b0;
        chk("t1_x0_data", rs1_data_pyro, 64'd0);
        tick();

        // 2: claim x7, read blocked until the write arrives
        claim_pyri = 5'd7; claim_valid_pyri = 1'b1;
        #1 chk("t2_claim_retry", 64'(claim_retry_pyro), 64'd0);
        tick();
        claim_valid_pyri = 1'b0;
        rs1_addr_pyri = 5'd7; rs1_addr_valid_pyri = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t2_busy_retry", 64'(rs1_addr_retry_pyro), 64'd1);
            tick();
        end
        wr_set(7, 64'h1234);
`ifdef PYRM_REGFILE_BYPASS_EN
        #1 chk("t2_bypass_accept", 64'(rs1_addr_retry_pyro), 64'd0);
        q1.push_back(64'h1234);
        tick();
        wr_clr();
`else
        #1 chk("t2_commit_cycle_retry", 64'(rs1_addr_retry_pyro), 64'd1);
        tick();
        wr_clr();
        #1 chk("t2_after_commit_accept", 64'(rs1_addr_retry_pyro), 64'd0);
        q1.push_back(64'h1234);
        tick();
`endif
        rs1_addr_valid_pyri = 1'b0;
        chk("t2_x7_valid", 64'(rs1_data_valid_pyro), 64'd1);
        chk("t2_x7_data", rs1_data_pyro, 64'h1234);
        tick();

        // 3: hold operand under consumer stall
        wr_set(3, 64'hAA);
        tick();
        wr_clr();
        rs1_addr_pyri = 5'd3; rs1_addr_valid_pyri = 1'b1; rs1_data_retry_pyri = 1'b1;
        q1.push_back(64'hAA);
        tick();
        rs1_addr_pyri = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_hold_valid", 64'(rs1_data_valid_pyro), 64'd1);
            chk("t3_hold_data", rs1_data_pyro, 64'hAA);
            chk("t3_new_req_retry", 64'(rs1_addr_retry_pyro), 64'd1);
            tick();
        end
        rs1_data_retry_pyri = 1'b0;
        #1 chk("t3_release_accept", 64'(rs1_addr_retry_pyro), 64'd0);
        q1.push_back(64'h1234);
        tick();
        rs1_addr_valid_pyri = 1'b0;
        chk("t3_new_data", rs1_data_pyro, 64'h1234);
        tick();

        // 4: WAW claim retry, cleared by a same-cycle write; claim keeps busy set
        claim_pyri = 5'd9; claim_valid_pyri = 1'b1;
        tick();
        #1 chk("t4_waw_retry", 64'(claim_retry_pyro), 64'd1);
        wr_set(9, 64'h99);
        #1 chk("t4_write_frees_claim", 64'(claim_retry_pyro), 64'd0);
        tick();
        wr_clr();
        claim_valid_pyri = 1'b0;
        rs2_addr_pyri = 5'd9; rs2_addr_valid_pyri = 1'b1;
        #1 chk("t4_still_busy", 64'(rs2_addr_retry_pyro), 64'd1);
        rs2_addr_valid_pyri = 1'b0;
        wr_set(9, 64'h999);
        tick();
        wr_clr();
        rs1_addr_pyri = 5'd9; rs1_addr_valid_pyri = 1'b1;
        rs2_addr_pyri = 5'd9; rs2_addr_valid_pyri = 1'b1;
        q1.push_back(64'h999);
        q2.push_back(64'h999);
        tick();
        rs1_addr_valid_pyri = 1'b0; rs2_addr_valid_pyri = 1'b0;
        chk("t4_dual_rs2_data", rs2_data_pyro, 64'h999);
        tick();

        // 5: address-only write has no effect
        wr_addr_pyri = 64'd4; wr_data_pyri = 64'h55;
        wr_addr_valid_pyri = 1'b1; wr_data_valid_pyri = 1'b0;
        tick();
        wr_clr();
        rs1_addr_pyri = 5'd4; rs1_addr_valid_pyri = 1'b1;
        q1.push_back(64'd0);
        tick();
        rs1_addr_valid_pyri = 1'b0;
        chk("t5_x4_unchanged", rs1_data_pyro, 64'd0);
        wr_set(4, 64'h55);
        tick();
        wr_clr();
        rs1_addr_valid_pyri = 1'b1;
        q1.push_back(64'h55);
        tick();
        rs1_addr_valid_pyri = 1'b0;
        chk("t5_x4_written", rs1_data_pyro, 64'h55);
        tick();

        // 6: async reset mid-cycle drops pending operand and busy bits
        claim_pyri = 5'd12; claim_valid_pyri = 1'b1;
        tick();
        claim_valid_pyri = 1'b0;
        rs2_addr_pyri = 5'd3; rs2_addr_valid_pyri = 1'b1; rs2_data_retry_pyri = 1'b1;
        tick();
        rs2_addr_valid_pyri = 1'b0;
        chk("t6_rs2_pending", 64'(rs2_data_valid_pyro), 64'd1);
        #2 reset_pyri = 1'b0;
        #1;
        chk("t6_async_valid_clear", 64'(rs2_data_valid_pyro), 64'd0);
        chk("t6_async_data_clear", rs2_data_pyro, 64'd0);
        rs1_addr_pyri = 5'd12; rs1_addr_valid_pyri = 1'b1;
        #1 chk("t6_busy_cleared", 64'(rs1_addr_retry_pyro), 64'd0);
        rs1_addr_valid_pyri = 1'b0;
        rs2_data_retry_pyri = 1'b0;
        tick();
        reset_pyri = 1'b1;
        tick();
        rs1_addr_pyri = 5'd12; rs1_addr_valid_pyri = 1'b1;
        rs2_addr_pyri = 5'd3;  rs2_addr_valid_pyri = 1'b1;
        #1 chk("t6_x12_read_accept", 64'(rs1_addr_retry_pyro), 64'd0);
        q1.push_back(64'd0);
        q2.push_back(64'd0);
        tick();
        rs1_addr_valid_pyri = 1'b0; rs2_addr_valid_pyri = 1'b0;
        chk("t6_x12_data", rs1_data_pyro, 64'd0);
        chk("t6_x3_cleared", rs2_data_pyro, 64'd0);
        tick();
        tick();

        chk("q1_drained", 64'(q1.size()), 64'd0);
        chk("q2_drained", 64'(q2.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
